// File: rtl/ex_muldiv_pkg.sv
// ============================================================================
//  Module   : ex_muldiv_pkg
//  Brief    : Shared op encodings, FSM states and iteration constants for the
//             EX-stage iterative multiply/divide unit.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package ex_muldiv_pkg;

   // Operation encodings presented on op with start
   localparam logic [2:0] c_op_mult  = 3'b000;
   localparam logic [2:0] c_op_multu = 3'b001;
   localparam logic [2:0] c_op_div   = 3'b010;
   localparam logic [2:0] c_op_divu  = 3'b011;
   localparam logic [2:0] c_op_mthi  = 3'b100;
   localparam logic [2:0] c_op_mtlo  = 3'b101;

   // One shift-add / subtract-shift step per bit of the 32-bit operands
   localparam int unsigned c_iter_count = 32;
   localparam int unsigned c_cnt_w      = 5;
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_iter_count - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/ex_muldiv_if.sv
// ============================================================================
//  Module   : ex_muldiv_if
//  Brief    : EX-stage request / HI-LO result bundle for ex_muldiv.
//             master = pipeline side, slave = multiply/divide unit.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface ex_muldiv_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        flush;
   logic        hilo_rd;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;
   logic        stall_req;

   modport master (
      output start, op, a, b, flush, hilo_rd,
      input  hi, lo, busy, done, stall_req
   );

   modport slave (
      input  start, op, a, b, flush, hilo_rd,
      output hi, lo, busy, done, stall_req
   );
endinterface

`default_nettype wire

// File: rtl/ex_muldiv_signfix.sv
// ============================================================================
//  Module   : muldiv_signfix
//  Brief    : Combinational operand magnitude extraction and result sign
//             correction shared by the multiply and divide datapaths.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_signfix
   import ex_muldiv_pkg::*;
(
   // operand side, used when a request is accepted
   input  wire logic [31:0] i_a,
   input  wire logic [31:0] i_b,
   input  wire logic        i_signed,
   output logic [31:0]      o_mag_a,
   output logic [31:0]      o_mag_b,
   output logic             o_neg_q,   // product / quotient must be negated
   output logic             o_neg_r,   // remainder must be negated
   // result side, used at commit with the latched sign flags
   input  wire logic [63:0] i_prod,
   input  wire logic [31:0] i_quo,
   input  wire logic [31:0] i_rem,
   input  wire logic        i_neg_q,
   input  wire logic        i_neg_r,
   output logic [63:0]      o_prod,
   output logic [31:0]      o_quo,
   output logic [31:0]      o_rem
);

   logic w_sa;
   logic w_sb;

   assign w_sa = i_signed & i_a[31];
   assign w_sb = i_signed & i_b[31];

   // 32'h80000000 negates to itself, which is exactly its unsigned magnitude
   assign o_mag_a = w_sa ? (~i_a + 32'd1) : i_a;
   assign o_mag_b = w_sb ? (~i_b + 32'd1) : i_b;
   assign o_neg_q = w_sa ^ w_sb;
   assign o_neg_r = w_sa;

   assign o_prod = i_neg_q ? (~i_prod + 64'd1) : i_prod;
   assign o_quo  = i_neg_q ? (~i_quo + 32'd1) : i_quo;
   assign o_rem  = i_neg_r ? (~i_rem + 32'd1) : i_rem;

endmodule

`default_nettype wire

// File: rtl/ex_muldiv.sv
// ============================================================================
//  Module   : ex_muldiv
//  Brief    : Iterative 32-cycle MULT/MULTU/DIV/DIVU unit with HI/LO
//             registers, MTHI/MTLO writes, flush abort and stall request.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ex_muldiv
   import ex_muldiv_pkg::*;
(
   input  wire logic   clk,
   input  wire logic   rst,
   ex_muldiv_if.slave  bus
);

   // Datapath registers are shared between the two iterative modes:
   //   MUL : r_acc = running product, r_opa = shifted multiplicand,
   //         r_opb = multiplier (consumed LSB first)
   //   DIV : r_acc[31:0] = partial remainder, r_opa[31:0] = divisor,
   //         r_opb = dividend shifting out / quotient shifting in
   state_t             r_state;
   logic [c_cnt_w-1:0] r_cnt;
   logic [31:0]        r_hi;
   logic [31:0]        r_lo;
   logic               r_done;
   logic [63:0]        r_acc;
   logic [63:0]        r_opa;
   logic [31:0]        r_opb;
   logic               r_neg_q;
   logic               r_neg_r;
   logic               r_dz;
   logic [31:0]        r_a_raw;

   state_t             w_state_nxt;
   logic [c_cnt_w-1:0] w_cnt_nxt;
   logic [31:0]        w_hi_nxt;
   logic [31:0]        w_lo_nxt;
   logic               w_done_nxt;
   logic [63:0]        w_acc_nxt;
   logic [63:0]        w_opa_nxt;
   logic [31:0]        w_opb_nxt;
   logic               w_neg_q_nxt;
   logic               w_neg_r_nxt;
   logic               w_dz_nxt;
   logic [31:0]        w_a_raw_nxt;

   logic               w_is_signed;
   logic [31:0]        w_mag_a;
   logic [31:0]        w_mag_b;
   logic               w_neg_q;
   logic               w_neg_r;
   logic [63:0]        w_mul_acc;
   logic [32:0]        w_div_shift;
   logic [33:0]        w_div_sub;
   logic [31:0]        w_div_rem;
   logic [31:0]        w_div_quo;
   logic [63:0]        w_prod_fix;
   logic [31:0]        w_quo_fix;
   logic [31:0]        w_rem_fix;

   assign w_is_signed = (bus.op == c_op_mult) || (bus.op == c_op_div);

   // One shift-add multiply step
   assign w_mul_acc = r_opb[0] ? (r_acc + r_opa) : r_acc;

   // One restoring divide step; a clear borrow bit means the trial fits
   assign w_div_shift = {r_acc[31:0], r_opb[31]};
   assign w_div_sub   = {1'b0, w_div_shift} - {2'b00, r_opa[31:0]};
   assign w_div_rem   = w_div_sub[33] ? w_div_shift[31:0] : w_div_sub[31:0];
   assign w_div_quo   = {r_opb[30:0], ~w_div_sub[33]};

   muldiv_signfix u_signfix (
      .i_a      (bus.a),
      .i_b      (bus.b),
      .i_signed (w_is_signed),
      .o_mag_a  (w_mag_a),
      .o_mag_b  (w_mag_b),
      .o_neg_q  (w_neg_q),
      .o_neg_r  (w_neg_r),
      .i_prod   (w_mul_acc),
      .i_quo    (w_div_quo),
      .i_rem    (w_div_rem),
      .i_neg_q  (r_neg_q),
      .i_neg_r  (r_neg_r),
      .o_prod   (w_prod_fix),
      .o_quo    (w_quo_fix),
      .o_rem    (w_rem_fix)
   );

   // Next-state, iteration and HI/LO commit logic
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_hi_nxt    = r_hi;
      w_lo_nxt    = r_lo;
      w_done_nxt  = 1'b0;
      w_acc_nxt   = r_acc;
      w_opa_nxt   = r_opa;
      w_opb_nxt   = r_opb;
      w_neg_q_nxt = r_neg_q;
      w_neg_r_nxt = r_neg_r;
      w_dz_nxt    = r_dz;
      w_a_raw_nxt = r_a_raw;

      case (r_state)
         ST_IDLE: begin
            // A flush in the same cycle kills the request, MTHI/MTLO included
            if (bus.start && !bus.flush) begin
               case (bus.op)
                  c_op_mult, c_op_multu: begin
                     w_state_nxt = ST_MUL;
                     w_cnt_nxt   = '0;
                     w_acc_nxt   = '0;
                     w_opa_nxt   = {32'd0, w_mag_a};
                     w_opb_nxt   = w_mag_b;
                     w_neg_q_nxt = w_neg_q;
                     w_neg_r_nxt = w_neg_r;
                     w_dz_nxt    = 1'b0;
                     w_a_raw_nxt = bus.a;
                  end
                  c_op_div, c_op_divu: begin
                     w_state_nxt = ST_DIV;
                     w_cnt_nxt   = '0;
                     w_acc_nxt   = '0;
                     w_opa_nxt   = {32'd0, w_mag_b};
                     w_opb_nxt   = w_mag_a;
                     w_neg_q_nxt = w_neg_q;
                     w_neg_r_nxt = w_neg_r;
                     w_dz_nxt    = (bus.b == 32'd0);
                     w_a_raw_nxt = bus.a;
                  end
                  c_op_mthi: w_hi_nxt = bus.a;
                  c_op_mtlo: w_lo_nxt = bus.a;
                  default: ;
               endcase
            end
         end

         ST_MUL: begin
            if (bus.flush) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_acc_nxt = w_mul_acc;
               w_opa_nxt = {r_opa[62:0], 1'b0};
               w_opb_nxt = {1'b0, r_opb[31:1]};
               w_cnt_nxt = r_cnt + 1'b1;
               if (r_cnt == c_cnt_last) begin
                  w_state_nxt = ST_IDLE;
                  w_cnt_nxt   = '0;
                  w_hi_nxt    = w_prod_fix[63:32];
                  w_lo_nxt    = w_prod_fix[31:0];
                  w_done_nxt  = 1'b1;
               end
            end
         end

         ST_DIV: begin
            if (bus.flush) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_acc_nxt = {32'd0, w_div_rem};
               w_opb_nxt = w_div_quo;
               w_cnt_nxt = r_cnt + 1'b1;
               if (r_cnt == c_cnt_last) begin
                  w_state_nxt = ST_IDLE;
                  w_cnt_nxt   = '0;
                  w_done_nxt  = 1'b1;
                  // Divide by zero returns the dividend in HI and all-ones in LO
                  if (r_dz) begin
                     w_hi_nxt = r_a_raw;
                     w_lo_nxt = 32'hFFFF_FFFF;
                  end else begin
                     w_hi_nxt = w_rem_fix;
                     w_lo_nxt = w_quo_fix;
                  end
               end
            end
         end

         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // All sequential state; reset overrides flush and start
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_done  <= 1'b0;
         r_acc   <= '0;
         r_opa   <= '0;
         r_opb   <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_dz    <= 1'b0;
         r_a_raw <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_hi    <= w_hi_nxt;
         r_lo    <= w_lo_nxt;
         r_done  <= w_done_nxt;
         r_acc   <= w_acc_nxt;
         r_opa   <= w_opa_nxt;
         r_opb   <= w_opb_nxt;
         r_neg_q <= w_neg_q_nxt;
         r_neg_r <= w_neg_r_nxt;
         r_dz    <= w_dz_nxt;
         r_a_raw <= w_a_raw_nxt;
      end
   end

   assign bus.hi        = r_hi;
   assign bus.lo        = r_lo;
   assign bus.busy      = (r_state != ST_IDLE);
   assign bus.done      = r_done;
   assign bus.stall_req = bus.busy & (bus.start | bus.hilo_rd);

endmodule

`default_nettype wire

// File: tb/tb_ex_muldiv.sv
// ============================================================================
//  Module   : tb_ex_muldiv
//  Brief    : Scoreboard bench for ex_muldiv: expected HI/LO pushed when a
//             request is driven, popped and compared when done pulses.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ex_muldiv;
   import ex_muldiv_pkg::*;

   typedef struct {
      logic [2:0]  op;
      logic [63:0] hilo;
   } sb_entry_t;

   logic        clk;
   logic        rst;
   int          n_checks;
   int          n_errors;
   sb_entry_t   sb_q[$];
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   ex_muldiv_if bus ();

   ex_muldiv u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference model: returns {hi, lo}
   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      longint      sa;
      longint      sb;
      logic [63:0] q;
      logic [63:0] r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         c_op_mult:  return 64'(sa * sb);
         c_op_multu: return {32'd0, a} * {32'd0, b};
         c_op_div: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            q = 64'(sa / sb);
            r = 64'(sa % sb);
            return {r[31:0], q[31:0]};
         end
         c_op_divu: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         default: return {m_hi, m_lo};
      endcase
   endfunction

   // Scoreboard consumer
   always @(negedge clk) begin
      if (!rst && bus.done) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
         end else begin
            sb_entry_t e;
            e = sb_q.pop_front();
            chk("hi", {32'd0, bus.hi}, {32'd0, e.hilo[63:32]});
            chk("lo", {32'd0, bus.lo}, {32'd0, e.hilo[31:0]});
         end
      end
   end

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit disturb);
      sb_entry_t e;
      int        nb;
      int        stall_low;
      e.op   = op;
      e.hilo = model(op, a, b);
      sb_q.push_back(e);
      m_hi = e.hilo[63:32];
      m_lo = e.hilo[31:0];
      @(negedge clk);
      bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
      @(negedge clk);
      bus.start = 1'b0;
      if (disturb) bus.hilo_rd = 1'b1;
      nb = 0;
      stall_low = 0;
      while (bus.busy && nb < 40) begin
         if (disturb && !bus.stall_req) stall_low++;
         if (disturb && nb == 5) begin
            bus.start = 1'b1; bus.op = c_op_divu; bus.a = $urandom; bus.b = $urandom;
         end else begin
            bus.start = 1'b0;
         end
         nb++;
         @(negedge clk);
      end
      bus.start = 1'b0;
      chk("busy_cycles", 64'(nb), 64'd32);
      chk("done_pulse", {63'd0, bus.done}, 64'd1);
      if (disturb) begin
         chk("stall_while_busy", 64'(stall_low), 64'd0);
         chk("stall_after_idle", {63'd0, bus.stall_req}, 64'd0);
         bus.hilo_rd = 1'b0;
      end
      @(negedge clk);
      chk("done_one_cycle", {63'd0, bus.done}, 64'd0);
   endtask

   // DIVU 1000/7 aborted after 10 busy cycles by flush or by reset
   task automatic abort_op(input bit use_rst);
      int nb;
      @(negedge clk);
      bus.start = 1'b1; bus.op = c_op_divu; bus.a = 32'd1000; bus.b = 32'd7;
      @(negedge clk);
      bus.start = 1'b0;
      nb = 0;
      while (bus.busy && nb < 10) begin
         nb++;
         @(negedge clk);
      end
      if (use_rst) rst = 1'b1; else bus.flush = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.flush = 1'b0;
      if (use_rst) begin
         m_hi = 32'd0;
         m_lo = 32'd0;
      end
      chk(use_rst ? "rst_busy" : "flush_busy", {63'd0, bus.busy}, 64'd0);
      chk(use_rst ? "rst_hi" : "flush_hi", {32'd0, bus.hi}, {32'd0, m_hi});
      chk(use_rst ? "rst_lo" : "flush_lo", {32'd0, bus.lo}, {32'd0, m_lo});
      chk("abort_no_done", {63'd0, bus.done}, 64'd0);
      @(negedge clk);
      chk("abort_no_done_later", {63'd0, bus.done}, 64'd0);
   endtask

   task automatic move_op(input logic [2:0] op, input logic [31:0] a);
      @(negedge clk);
      bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = 32'd0;
      @(negedge clk);
      bus.start = 1'b0;
      if (op == c_op_mthi) m_hi = a; else m_lo = a;
      chk("move_hi", {32'd0, bus.hi}, {32'd0, m_hi});
      chk("move_lo", {32'd0, bus.lo}, {32'd0, m_lo});
      chk("move_busy", {63'd0, bus.busy}, 64'd0);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      m_hi = 32'd0;
      m_lo = 32'd0;
      rst = 1'b1;
      bus.start = 1'b0; bus.op = 3'd0; bus.a = 32'd0; bus.b = 32'd0;
      bus.flush = 1'b0; bus.hilo_rd = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_hi", {32'd0, bus.hi}, 64'd0);
      chk("reset_lo", {32'd0, bus.lo}, 64'd0);
      chk("reset_busy", {63'd0, bus.busy}, 64'd0);
      chk("reset_done", {63'd0, bus.done}, 64'd0);
      rst = 1'b0;

      run_op(c_op_multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op(c_op_mult,  32'hFFFF_FFFD, 32'd7, 1'b1);
      run_op(c_op_div,   32'hFFFF_FFF9, 32'd2, 1'b0);
      run_op(c_op_divu,  32'd100, 32'd0, 1'b0);
      run_op(c_op_div,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op(c_op_div,   32'hFFFF_FF00, 32'd0, 1'b0);
      run_op(c_op_div,   32'd7, 32'hFFFF_FFFE, 1'b0);

      move_op(c_op_mthi, 32'h1234_5678);
      move_op(c_op_mtlo, 32'hCAFE_F00D);

      abort_op(1'b0);
      abort_op(1'b1);

      // Flush coinciding with a request in IDLE suppresses it
      @(negedge clk);
      bus.start = 1'b1; bus.op = c_op_mthi; bus.a = 32'hDEAD_BEEF; bus.flush = 1'b1;
      @(negedge clk);
      bus.op = c_op_mult;
      @(negedge clk);
      bus.start = 1'b0; bus.flush = 1'b0;
      chk("idle_flush_hi", {32'd0, bus.hi}, {32'd0, m_hi});
      chk("idle_flush_busy", {63'd0, bus.busy}, 64'd0);

      for (int i = 0; i < 8; i++) begin
         logic [2:0]  rop;
         logic [31:0] ra;
         logic [31:0] rb;
         rop = 3'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
         if (rop == c_op_div && i == 3) rb = 32'hFFFF_FFF0;
         run_op(rop, ra, rb, 1'b0);
      end

      repeat (3) @(negedge clk);
      chk("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  reset; synchronous, active-high; sampled only on the rising edge of clk.
REQ-003 start  input  1  EX-stage request; qualifies op/a/b for one cycle.
REQ-004 op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved, treated as no-op.
REQ-005 a  input  32  operand Rs after forwarding (dividend / multiplicand / MTHI-MTLO source).
REQ-006 b  input  32  operand Rt after forwarding (divisor / multiplier).
REQ-007 flush  input  1  abort from hazard unit; same priority class as ID/EX flush.
REQ-008 hilo_rd  input  1  MFHI/MFLO present in EX this cycle.
REQ-009 hi  output  32  HI register.
REQ-010 lo  output  32  LO register.
REQ-011 busy  output  1  high while an iterative operation is in progress.
REQ-012 done  output  1  one-cycle pulse, cycle after HI/LO commit.
REQ-013 stall_req  output  1  combinational: busy & (start | hilo_rd); drives hazard-unit stall encoding 2'b10.

Function
REQ-014 FSM states: IDLE, MUL, DIV; busy = (state != IDLE).
REQ-015 IDLE & start & op in {MULT,MULTU}: latch operands, state->MUL, count->0.
REQ-016 IDLE & start & op in {DIV,DIVU}: latch operands, state->DIV, count->0.
REQ-017 IDLE & start & MTHI: hi<=a at that edge; MTLO: lo<=a; state stays IDLE; busy never asserts.
REQ-018 start while busy: ignored; no operand re-latch; stall_req high.
REQ-019 MUL: one shift-add step per cycle, 32 steps (count 0..31); 64-bit product.
REQ-020 DIV: one restoring subtract-shift step per cycle, 32 steps; quotient->lo, remainder->hi.
REQ-021 Signed ops: operate on magnitudes; product negated if sign(a)!=sign(b); quotient negated if signs differ; remainder takes sign of a.
REQ-022 Latency: start accepted at edge N; hi/lo updated at edge N+32; state IDLE from edge N+32; done=1 for the cycle after edge N+32 only.
REQ-023 Divide by zero (any sign): hi<=a, lo<=32'hFFFFFFFF, same 32-cycle latency.
REQ-024 DIV 32'h80000000 / 32'hFFFFFFFF: lo=32'h80000000, hi=0; no exception.
REQ-025 flush while busy: state->IDLE next edge, hi/lo unchanged, done not asserted.
REQ-026 flush & start same cycle in IDLE: start ignored, including MTHI/MTLO.
REQ-027 count is 5 bits; terminal at 31, no wrap into a 33rd step.
REQ-028 hi/lo change only on commit (REQ-022), MTHI/MTLO, or reset.

Reset
REQ-029 rst has priority over flush and start.
REQ-030 Reset values: state IDLE, count 0, hi 0, lo 0, busy 0, done 0, internal operand/accumulator registers 0.
REQ-031 rst mid-operation: next edge returns all of REQ-030; no partial commit.
REQ-032 No initial blocks; reset is the only initialisation path.

Structure
REQ-033 Shared package holds op encodings (REQ-004), FSM state encodings, and the iteration count constant 32.
REQ-034 One sub-module, muldiv_signfix: combinational magnitude extraction and result sign correction, shared by MUL and DIV paths.
REQ-035 Single always block for sequential state; next-state/datapath logic separate and combinational.

Verification
REQ-036 MULTU a=32'hFFFFFFFF b=32'hFFFFFFFF -> after 32 cycles hi=32'hFFFFFFFE, lo=32'h00000001, done one cycle.
REQ-037 MULT a=-3 (32'hFFFFFFFD) b=7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB; busy high exactly 32 cycles.
REQ-038 DIV a=-7 b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIVU a=100 b=0 -> hi=100, lo=32'hFFFFFFFF.
REQ-039 DIVU 1000/7 started; flush at cycle 10 -> IDLE next edge, hi/lo keep prior values, no done; rst at cycle 10 of a second run -> hi=lo=0.
REQ-040 MTHI a=32'h12345678 in IDLE -> hi=32'h12345678 next edge, busy 0; hilo_rd during MULT -> stall_req=1 until the cycle state returns to IDLE.
